// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared ALU mode codes, opcode constants, decode record and FSM states
package alu_issue_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    typedef struct packed {
        logic [3:0]  mode;
        logic        use_imm;
        logic [31:0] imm;
        logic        shamt_form;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } decode_t;

    // funct3 to ALU mode; alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] f3_mode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_mode = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  f3_mode = ALU_OP_SLL;
            3'b010:  f3_mode = ALU_OP_SLT;
            3'b011:  f3_mode = ALU_OP_SLTU;
            3'b100:  f3_mode = ALU_OP_XOR;
            3'b101:  f3_mode = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  f3_mode = ALU_OP_OR;
            default: f3_mode = ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// alu: registered 32-bit ALU, result appears one cycle after operands
module alu
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [3:0]  mode,
    output logic [31:0] rd
);

    logic [31:0] res;

    // combinational result selected by mode
    always_comb begin
        res = '0;
        case (mode)
            ALU_OP_ADD:  res = rs1 + rs2;
            ALU_OP_SUB:  res = rs1 - rs2;
            ALU_OP_SLL:  res = rs1 << rs2[4:0];
            ALU_OP_SLT:  res = {31'b0, $signed(rs1) < $signed(rs2)};
            ALU_OP_SLTU: res = {31'b0, rs1 < rs2};
            ALU_OP_XOR:  res = rs1 ^ rs2;
            ALU_OP_SRL:  res = rs1 >> rs2[4:0];
            ALU_OP_SRA:  res = $unsigned($signed(rs1) >>> rs2[4:0]);
            ALU_OP_OR:   res = rs1 | rs2;
            ALU_OP_AND:  res = rs1 & rs2;
            default:     res = '0;
        endcase
    end

    // result register
    always_ff @(posedge clk or posedge reset)
        if (reset) rd <= '0;
        else       rd <= res;

endmodule

// File: rtl/alu_decode.sv
// alu_decode: maps an RV32I OP/OP-IMM word to ALU mode, operand selection and legality
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       is_op;
    logic       is_imm;
    logic       shift;

    assign opc    = instr[6:0];
    assign f7     = instr[31:25];
    assign f3     = instr[14:12];
    assign is_op  = opc == OPC_OP;
    assign is_imm = opc == OPC_OP_IMM;
    assign shift  = f3 == 3'b001 || f3 == 3'b101;

    // field extraction and legality; immediate funct7 only matters for shifts
    always_comb begin
        dec            = '0;
        dec.rs1        = instr[19:15];
        dec.rs2        = instr[24:20];
        dec.rd         = instr[11:7];
        dec.imm        = {{20{instr[31]}}, instr[31:20]};
        dec.use_imm    = is_imm;
        dec.shamt_form = is_imm && shift;
        dec.mode       = f3_mode(f3, f7 == F7_ALT && (is_op || shift));
        dec.illegal    = is_op  ? !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) :
                         is_imm ? shift && !(f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'b101)) :
                         1'b1;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: serialized issue/writeback controller around a registered ALU with a 32x32 register file
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [3:0]  alu_mode,
    input  logic [31:0] alu_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      state, state_nxt;
    decode_t     dec;
    logic [31:0] regs [32];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        accept;

    alu_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    assign accept   = instr_valid && instr_ready;
    assign rs1_val  = dec.rs1 == 5'd0 ? '0 : regs[dec.rs1];
    assign rs2_val  = dec.use_imm ? (dec.shamt_form ? {27'b0, dec.rs2} : dec.imm) :
                      dec.rs2 == 5'd0 ? '0 : regs[dec.rs2];
    assign wb_data  = alu_rd;
    assign dbg_data = dbg_addr == 5'd0 ? '0 : regs[dbg_addr];

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;

    // illegal words are consumed without leaving IDLE
    always_comb begin
        state_nxt = state == IDLE ? (accept && !dec.illegal ? EXEC : IDLE) :
                    state == EXEC ? WB : IDLE;
    end

    // state-decoded handshake and writeback strobe
    always_comb begin
        instr_ready = state == IDLE;
        wb_valid    = state == WB;
    end

    // operand/mode/destination capture at accept and the illegal pulse
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_mode <= '0;
            wb_addr  <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= accept && dec.illegal;
            if (accept && !dec.illegal) begin
                alu_rs1  <= rs1_val;
                alu_rs2  <= rs2_val;
                alu_mode <= dec.mode;
                wb_addr  <= dec.rd;
            end
        end

    // register file write at the WB exit edge; x0 is never written
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == WB && wb_addr != 5'd0) begin
            regs[wb_addr] <= alu_rd;
        end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue driving a registered alu
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] alu_rs1, alu_rs2, alu_rd, wb_data, dbg_data;
    logic [3:0]  alu_mode;
    logic        wb_valid, illegal;
    logic [4:0]  wb_addr;
    logic [4:0]  dbg_addr = '0;

    int          checks = 0;
    int          errors = 0;
    int          wb_seen = 0;
    logic [36:0] sb [$];
    logic [36:0] sb_e;
    logic [31:0] model [32];

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_mode    (alu_mode),
        .alu_rd      (alu_rd),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    alu u_alu (
        .clk   (clk),
        .reset (reset),
        .rs1   (alu_rs1),
        .rs2   (alu_rs2),
        .mode  (alu_mode),
        .rd    (alu_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    // scoreboard: every writeback cycle pops one expected {addr,data}
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            wb_seen++;
            if (sb.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
            else begin
                sb_e = sb.pop_front();
                check("wb_addr", {27'b0, wb_addr}, {27'b0, sb_e[36:32]});
                check("wb_data", wb_data, sb_e[31:0]);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [3:0] md, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res);
        wait_ready();
        instr = ins;
        instr_valid = 1'b1;
        sb.push_back({rd, res});
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        check("alu_mode", {28'b0, alu_mode}, {28'b0, md});
        check("alu_rs2", alu_rs2, b);
        check("ready_exec", {31'b0, instr_ready}, 32'd0);
        if (rd != 5'd0) model[rd] = res;
        wait_ready();
        dbg_addr = rd;
        #1 check("dbg_reg", dbg_data, model[rd]);
    endtask

    task automatic issue_bad(input logic [31:0] ins);
        wait_ready();
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("illegal_pulse", {31'b0, illegal}, 32'd1);
        check("illegal_ready", {31'b0, instr_ready}, 32'd1);
        check("illegal_wb", {31'b0, wb_valid}, 32'd0);
        check("illegal_rs2", alu_rs2, 32'd7);
        @(negedge clk);
        check("illegal_drop", {31'b0, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dbg_addr = 5'd5;
        #1;
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_rs1", alu_rs1, 32'd0);
        check("rst_rs2", alu_rs2, 32'd0);
        check("rst_mode", {28'b0, alu_mode}, 32'd0);
        check("rst_wb", {26'b0, wb_valid, wb_addr}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_reg", dbg_data, 32'd0);

        issue(i_op(12'd5, 5'd0, 3'b000, 5'd1), ALU_OP_ADD, 32'd5, 5'd1, 32'd5);
        issue(i_op(12'hFFD, 5'd0, 3'b000, 5'd2), ALU_OP_ADD, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFD);
        issue(r_op(F7_BASE, 5'd2, 5'd1, 3'b000, 5'd3), ALU_OP_ADD, 32'hFFFF_FFFD, 5'd3, 32'd2);
        issue(r_op(F7_ALT, 5'd1, 5'd2, 3'b000, 5'd4), ALU_OP_SUB, 32'd5, 5'd4, 32'hFFFF_FFF8);
        issue(r_op(F7_BASE, 5'd1, 5'd2, 3'b011, 5'd5), ALU_OP_SLTU, 32'd5, 5'd5, 32'd0);
        issue(i_op({F7_ALT, 5'd1}, 5'd2, 3'b101, 5'd6), ALU_OP_SRA, 32'd1, 5'd6, 32'hFFFF_FFFE);
        issue(i_op(12'd1, 5'd2, 3'b101, 5'd7), ALU_OP_SRL, 32'd1, 5'd7, 32'h7FFF_FFFE);
        issue(r_op(F7_BASE, 5'd1, 5'd2, 3'b010, 5'd9), ALU_OP_SLT, 32'd5, 5'd9, 32'd1);
        issue(i_op(12'h0FF, 5'd1, 3'b100, 5'd10), ALU_OP_XOR, 32'hFF, 5'd10, 32'hFA);
        issue(r_op(F7_BASE, 5'd1, 5'd1, 3'b001, 5'd11), ALU_OP_SLL, 32'd5, 5'd11, 32'hA0);
        issue(i_op(12'h0F0, 5'd2, 3'b111, 5'd12), ALU_OP_AND, 32'hF0, 5'd12, 32'hF0);
        issue(r_op(F7_ALT, 5'd1, 5'd2, 3'b101, 5'd13), ALU_OP_SRA, 32'd5, 5'd13, 32'hFFFF_FFFF);
        issue(i_op(12'd7, 5'd0, 3'b000, 5'd0), ALU_OP_ADD, 32'd7, 5'd0, 32'd7);

        w = wb_seen;
        issue_bad(32'h0220_8033);
        issue_bad(i_op({F7_ALT, 5'd1}, 5'd1, 3'b001, 5'd14));
        issue_bad(32'h0000_2083);
        check("illegal_no_wb", wb_seen, w);
        dbg_addr = 5'd14;
        #1 check("illegal_no_write", dbg_data, 32'd0);

        wait_ready();
        instr = i_op(12'd9, 5'd0, 3'b000, 5'd8);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("abort_in_exec", {31'b0, instr_ready}, 32'd0);
        #2 reset = 1'b1;
        #1 check("abort_wb_low", {31'b0, wb_valid}, 32'd0);
        w = wb_seen;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_wb", wb_seen, w);
        check("abort_ready", {31'b0, instr_ready}, 32'd1);
        check("abort_outs", alu_rs1 | alu_rs2 | wb_data | {27'b0, wb_addr} | {28'b0, alu_mode}, 32'd0);
        check("abort_flags", {30'b0, wb_valid, illegal}, 32'd0);
        dbg_addr = 5'd8;
        #1 check("abort_x8", dbg_data, 32'd0);
        dbg_addr = 5'd1;
        #1 check("abort_x1", dbg_data, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
